// File: rtl/pms_fixture_pkg.sv
// Shared definitions for the PMS FPGA stimulus fixture:
// CSR offsets and the boot / I2C state encodings.
package pms_fixture_pkg;

    localparam logic [31:0] OFF_BOOTSEL = 32'h0000_0000;
    localparam logic [31:0] OFF_ENTRY   = 32'h0000_0004;
    localparam logic [31:0] OFF_FETCH   = 32'h0000_0008;
    localparam logic [31:0] OFF_EOC     = 32'h0000_000C;

    typedef enum logic [2:0] {
        B_IDLE,
        B_RST,
        B_WR_BOOTSEL,
        B_WR_ENTRY,
        B_WR_FETCH,
        B_POLL_RD,
        B_POLL_WAIT,
        B_DONE
    } boot_state_e;

    typedef enum logic [2:0] {
        I_IDLE,
        I_START,
        I_BIT,
        I_ACK,
        I_HOLD,
        I_STOP
    } i2c_state_e;

endpackage

// File: rtl/pms_fixture_i2c_drv.sv
// I2C master byte-stream driver with quarter-period tick divider.
// SCL/SDA are decoded from state so reset releases the bus at once.
module pms_fixture_i2c_drv
    import pms_fixture_pkg::*;
#(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       i2c_valid_i,
    input  logic [7:0] i2c_data_i,
    input  logic       i2c_last_i,
    output logic       i2c_ready_o,
    output logic       scl_o,
    output logic       sda_oe_o,
    input  logic       sda_i,
    output logic       i2c_busy_o,
    output logic       nack_o,
    output logic [7:0] nack_cnt_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    i2c_state_e       r_state;
    i2c_state_e       w_state_nx;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_q;
    logic [2:0]       r_bit;
    logic [7:0]       r_byte;
    logic             r_last;
    logic             r_ready;
    logic             r_nack;
    logic [7:0]       r_nack_cnt;
    logic [1:0]       r_sda_sync;
    logic             w_tick;
    logic             w_accept;

    assign w_tick = (r_div == DIV_LAST);

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        scl_o      = 1'b1;
        sda_oe_o   = 1'b0;
        unique case (r_state)
            I_IDLE: begin
                if (i2c_valid_i) begin
                    w_accept   = 1'b1;
                    w_state_nx = I_START;
                end
            end
            I_START: begin
                sda_oe_o = 1'b1;
                scl_o    = (r_q == 2'd0);
                if (w_tick && r_q == 2'd1) w_state_nx = I_BIT;
            end
            I_BIT: begin
                scl_o    = (r_q == 2'd1) || (r_q == 2'd2);
                sda_oe_o = ~r_byte[r_bit];
                if (w_tick && r_q == 2'd3 && r_bit == 3'd0) w_state_nx = I_ACK;
            end
            I_ACK: begin
                scl_o = (r_q == 2'd1) || (r_q == 2'd2);
                if (w_tick && r_q == 2'd3) begin
                    if (r_last) begin
                        w_state_nx = I_STOP;
                    end else if (i2c_valid_i) begin
                        w_accept   = 1'b1;
                        w_state_nx = I_BIT;
                    end else begin
                        w_state_nx = I_HOLD;
                    end
                end
            end
            I_HOLD: begin
                scl_o = 1'b0;
                if (i2c_valid_i) begin
                    w_accept   = 1'b1;
                    w_state_nx = I_BIT;
                end
            end
            I_STOP: begin
                scl_o    = (r_q != 2'd0);
                sda_oe_o = (r_q != 2'd2);
                if (w_tick && r_q == 2'd2) w_state_nx = I_IDLE;
            end
            default: w_state_nx = I_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= I_IDLE;
            r_div      <= '0;
            r_q        <= 2'd0;
            r_bit      <= 3'd7;
            r_byte     <= 8'h00;
            r_last     <= 1'b0;
            r_ready    <= 1'b0;
            r_nack     <= 1'b0;
            r_nack_cnt <= 8'h00;
            r_sda_sync <= 2'b11;
        end else begin
            r_state    <= w_state_nx;
            r_ready    <= w_accept;
            r_sda_sync <= {r_sda_sync[0], sda_i};
            // Divider idles while waiting so each new phase gets a full quarter
            if (r_state == I_IDLE || r_state == I_HOLD || w_tick) r_div <= '0;
            else r_div <= r_div + 1'b1;
            if (w_state_nx != r_state) r_q <= 2'd0;
            else if (w_tick) r_q <= r_q + 2'd1;
            if (w_accept) begin
                r_byte <= i2c_data_i;
                r_last <= i2c_last_i;
                r_bit  <= 3'd7;
            end else if (r_state == I_BIT && w_tick && r_q == 2'd3) begin
                r_bit <= r_bit - 3'd1;
            end
            if (r_state == I_IDLE && w_accept) begin
                r_nack     <= 1'b0;
                r_nack_cnt <= 8'h00;
            end else if (r_state == I_ACK && w_tick && r_q == 2'd1 && r_sda_sync[1]) begin
                r_nack <= 1'b1;
                if (r_nack_cnt != 8'hFF) r_nack_cnt <= r_nack_cnt + 8'd1;
            end
        end
    end

    assign i2c_ready_o = r_ready;
    assign i2c_busy_o  = (r_state != I_IDLE);
    assign nack_o      = r_nack;
    assign nack_cnt_o  = r_nack_cnt;

endmodule

// File: rtl/pms_top_fpga_fixture.sv
// FPGA-side PMS stimulus controller: boot sequencer over the CSR
// req/gnt port plus an independent I2C byte-stream driver.
module pms_top_fpga_fixture
    import pms_fixture_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 250,
    parameter int unsigned RST_CYCLES  = 500,
    parameter int unsigned POLL_CYCLES = 1000,
    parameter logic [31:0] BOOTMODE    = 32'h0000_0003,
    parameter logic [31:0] CSR_BASE    = 32'h1A10_4000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        boot_start_i,
    input  logic [31:0] entry_point_i,
    output logic        pms_rst_no,
    output logic        reg_req_o,
    output logic        reg_we_o,
    output logic [31:0] reg_addr_o,
    output logic [31:0] reg_wdata_o,
    input  logic        reg_gnt_i,
    input  logic        reg_rvalid_i,
    input  logic [31:0] reg_rdata_i,
    output logic        boot_done_o,
    output logic [31:0] exit_status_o,
    input  logic        i2c_valid_i,
    input  logic [7:0]  i2c_data_i,
    input  logic        i2c_last_i,
    output logic        i2c_ready_o,
    output logic        scl_o,
    output logic        sda_oe_o,
    input  logic        sda_i,
    output logic        i2c_busy_o,
    output logic        nack_o,
    output logic [7:0]  nack_cnt_o
);

    localparam logic [31:0] RST_LAST  = 32'(RST_CYCLES - 1);
    localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);

    boot_state_e r_state;
    boot_state_e w_state_nx;
    logic [31:0] r_cnt;
    logic [31:0] r_entry;
    logic [31:0] r_exit;
    logic        r_rst_n;
    logic        r_done;
    logic        r_rd_pend;
    logic        w_start;
    logic        w_rd_ok;

    assign w_start = boot_start_i && (r_state == B_IDLE || r_state == B_DONE);
    assign w_rd_ok = reg_rvalid_i && (r_rd_pend || reg_gnt_i);

    always_comb begin
        w_state_nx  = r_state;
        reg_req_o   = 1'b0;
        reg_we_o    = 1'b0;
        reg_addr_o  = 32'h0;
        reg_wdata_o = 32'h0;
        unique case (r_state)
            B_IDLE: if (w_start) w_state_nx = B_RST;
            B_RST:  if (r_cnt == RST_LAST) w_state_nx = B_WR_BOOTSEL;
            B_WR_BOOTSEL: begin
                reg_req_o   = 1'b1;
                reg_we_o    = 1'b1;
                reg_addr_o  = CSR_BASE + OFF_BOOTSEL;
                reg_wdata_o = BOOTMODE;
                if (reg_gnt_i) w_state_nx = B_WR_ENTRY;
            end
            B_WR_ENTRY: begin
                reg_req_o   = 1'b1;
                reg_we_o    = 1'b1;
                reg_addr_o  = CSR_BASE + OFF_ENTRY;
                reg_wdata_o = r_entry;
                if (reg_gnt_i) w_state_nx = B_WR_FETCH;
            end
            B_WR_FETCH: begin
                reg_req_o   = 1'b1;
                reg_we_o    = 1'b1;
                reg_addr_o  = CSR_BASE + OFF_FETCH;
                reg_wdata_o = 32'h0000_0001;
                if (reg_gnt_i) w_state_nx = B_POLL_RD;
            end
            B_POLL_RD: begin
                reg_req_o  = ~r_rd_pend;
                reg_addr_o = CSR_BASE + OFF_EOC;
                if (w_rd_ok) w_state_nx = reg_rdata_i[31] ? B_DONE : B_POLL_WAIT;
            end
            B_POLL_WAIT: if (r_cnt == POLL_LAST) w_state_nx = B_POLL_RD;
            B_DONE: if (w_start) w_state_nx = B_RST;
            default: w_state_nx = B_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= B_IDLE;
            r_cnt     <= 32'h0;
            r_entry   <= 32'h0;
            r_exit    <= 32'h0;
            r_rst_n   <= 1'b0;
            r_done    <= 1'b0;
            r_rd_pend <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= (w_state_nx != r_state) ? 32'h0 : r_cnt + 32'd1;
            r_done  <= (w_state_nx == B_DONE);
            if (w_state_nx == B_RST) r_rst_n <= 1'b0;
            else if (r_state == B_RST) r_rst_n <= 1'b1;
            if (w_start) r_entry <= entry_point_i;
            if (w_start) r_exit <= 32'h0;
            else if (r_state == B_POLL_RD && w_rd_ok && reg_rdata_i[31])
                r_exit <= {1'b0, reg_rdata_i[30:0]};
            // A granted read stays pending until its rvalid arrives
            if (r_state != B_POLL_RD || w_state_nx != B_POLL_RD) r_rd_pend <= 1'b0;
            else if (reg_req_o && reg_gnt_i) r_rd_pend <= 1'b1;
        end
    end

    assign pms_rst_no    = r_rst_n;
    assign boot_done_o   = r_done;
    assign exit_status_o = r_exit;

    pms_fixture_i2c_drv #(
        .CLK_DIV(CLK_DIV)
    ) u_i2c (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i2c_valid_i(i2c_valid_i),
        .i2c_data_i (i2c_data_i),
        .i2c_last_i (i2c_last_i),
        .i2c_ready_o(i2c_ready_o),
        .scl_o      (scl_o),
        .sda_oe_o   (sda_oe_o),
        .sda_i      (sda_i),
        .i2c_busy_o (i2c_busy_o),
        .nack_o     (nack_o),
        .nack_cnt_o (nack_cnt_o)
    );

endmodule

// File: tb/tb_pms_top_fpga_fixture.sv
// Bench for pms_top_fpga_fixture: CSR responder, I2C slave model,
// table-driven boot vectors and randomized I2C streams.
module tb_pms_top_fpga_fixture;

    localparam int unsigned CLK_DIV     = 2;
    localparam int unsigned RST_CYCLES  = 500;
    localparam int unsigned POLL_CYCLES = 1000;
    localparam logic [31:0] BOOTMODE    = 32'h0000_0003;
    localparam logic [31:0] CSR_BASE    = 32'h1A10_4000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        boot_start = 1'b0;
    logic [31:0] entry = 32'h0;
    logic        pms_rst_n;
    logic        reg_req, reg_we, reg_gnt, reg_rvalid;
    logic [31:0] reg_addr, reg_wdata, reg_rdata;
    logic        boot_done;
    logic [31:0] exit_status;
    logic        i2c_valid = 1'b0;
    logic [7:0]  i2c_data = 8'h00;
    logic        i2c_last = 1'b0;
    logic        i2c_ready, scl, sda_oe, sda_i, i2c_busy, nack;
    logic [7:0]  nack_cnt;
    logic        slave_low;

    always #5 clk = ~clk;
    assign sda_i = ~sda_oe & ~slave_low;

    pms_top_fpga_fixture #(
        .CLK_DIV(CLK_DIV), .RST_CYCLES(RST_CYCLES), .POLL_CYCLES(POLL_CYCLES),
        .BOOTMODE(BOOTMODE), .CSR_BASE(CSR_BASE)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .boot_start_i(boot_start),
        .entry_point_i(entry), .pms_rst_no(pms_rst_n),
        .reg_req_o(reg_req), .reg_we_o(reg_we), .reg_addr_o(reg_addr),
        .reg_wdata_o(reg_wdata), .reg_gnt_i(reg_gnt), .reg_rvalid_i(reg_rvalid),
        .reg_rdata_i(reg_rdata), .boot_done_o(boot_done),
        .exit_status_o(exit_status), .i2c_valid_i(i2c_valid),
        .i2c_data_i(i2c_data), .i2c_last_i(i2c_last), .i2c_ready_o(i2c_ready),
        .scl_o(scl), .sda_oe_o(sda_oe), .sda_i(sda_i), .i2c_busy_o(i2c_busy),
        .nack_o(nack), .nack_cnt_o(nack_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- CSR port responder ----------------
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          zeros = 0;
    logic [31:0] poll_data = 32'h0;
    logic [31:0] final_data = 32'h0;
    bit          gnt_rand = 1'b0;
    int          rd_idx = 0;
    bit          rd_pend = 1'b0;

    always @(negedge clk) begin
        reg_rvalid = 1'b0;
        reg_rdata  = 32'h0;
        if (boot_start) rd_idx = 0;
        if (rd_pend) begin
            reg_rvalid = 1'b1;
            reg_rdata  = (rd_idx < zeros) ? poll_data : final_data;
            rd_idx++;
            rd_pend = 1'b0;
        end
        reg_gnt = reg_req && (!gnt_rand || $urandom_range(0, 2) == 0);
        if (reg_gnt && !reg_we) rd_pend = 1'b1;
    end

    logic [31:0] wa_q[$], wd_q[$], ra_q[$];
    int unsigned rc_q[$];
    always @(posedge clk) begin
        if (boot_start) begin
            wa_q.delete(); wd_q.delete(); ra_q.delete(); rc_q.delete();
        end else if (reg_req && reg_gnt) begin
            if (reg_we) begin
                wa_q.push_back(reg_addr);
                wd_q.push_back(reg_wdata);
            end else begin
                ra_q.push_back(reg_addr);
                rc_q.push_back(cyc);
            end
        end
    end

    // ---------------- I2C slave model ----------------
    bit       nack_plan[300];
    logic [7:0] rx[$];
    logic [7:0] shreg;
    int  bitcnt, byte_idx, pulses, stops, rdy_cnt;
    bit  saw_rise, prev_scl, prev_sda, bus;

    always @(negedge clk) begin
        if (!rst_n) begin
            slave_low = 1'b0; bitcnt = 0; byte_idx = 0; saw_rise = 1'b0;
            prev_scl = 1'b1; prev_sda = 1'b1;
        end else begin
            bus = sda_i;
            if (scl && prev_scl && prev_sda && !bus) begin
                bitcnt = 0; byte_idx = 0; pulses = 0; stops = 0;
                rdy_cnt = 0; saw_rise = 1'b0; rx.delete();
            end else if (scl && prev_scl && !prev_sda && bus) begin
                stops++;
            end
            if (scl && !prev_scl) begin
                saw_rise = 1'b1;
                if (bitcnt < 8) begin
                    shreg = {shreg[6:0], bus};
                    bitcnt++;
                    if (bitcnt == 8) rx.push_back(shreg);
                end else begin
                    bitcnt = 9;
                end
            end
            if (!scl && prev_scl) begin
                if (saw_rise) pulses++;
                if (bitcnt == 8) begin
                    slave_low = !nack_plan[byte_idx];
                end else if (bitcnt == 9) begin
                    slave_low = 1'b0;
                    bitcnt = 0;
                    byte_idx++;
                end
            end
            if (i2c_ready) rdy_cnt++;
            prev_scl = scl;
            prev_sda = bus;
        end
    end

    // ---------------- I2C stimulus and model ----------------
    logic [7:0] tx_q[$];

    task automatic i2c_xfer(input int gap_max);
        int t;
        for (int i = 0; i < tx_q.size(); i++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
            i2c_data  = tx_q[i];
            i2c_last  = (i == tx_q.size() - 1);
            i2c_valid = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!i2c_ready && t < 4000);
            i2c_valid = 1'b0;
            i2c_last  = 1'b0;
            if (!i2c_ready) begin
                chk("i2c_ready_timeout", 32'd1, 32'd0);
                return;
            end
        end
        t = 0;
        while (i2c_busy && t < 4000) begin @(negedge clk); t++; end
        chk("i2c_idle_timeout", 32'(i2c_busy), 32'd0);
    endtask

    task automatic i2c_check(input string tag);
        int n, exp_nack, bad;
        n = tx_q.size();
        exp_nack = 0;
        for (int i = 0; i < n; i++) if (nack_plan[i]) exp_nack++;
        if (exp_nack > 255) exp_nack = 255;
        chk({tag, "_rx_count"}, 32'(rx.size()), 32'(n));
        bad = 0;
        for (int i = 0; i < n && i < rx.size(); i++) if (rx[i] !== tx_q[i]) bad++;
        chk({tag, "_rx_bytes_bad"}, 32'(bad), 32'd0);
        chk({tag, "_scl_pulses"}, 32'(pulses), 32'(9 * n));
        chk({tag, "_stops"}, 32'(stops), 32'd1);
        chk({tag, "_ready_cycles"}, 32'(rdy_cnt), 32'(n));
        chk({tag, "_nack"}, 32'(nack), 32'(exp_nack > 0));
        chk({tag, "_nack_cnt"}, 32'(nack_cnt), 32'(exp_nack));
        chk({tag, "_bus_released"}, {30'd0, scl, sda_oe}, 32'd2);
    endtask

    task automatic i2c_random(input int iters);
        for (int k = 0; k < iters; k++) begin
            tx_q.delete();
            for (int i = 0; i < $urandom_range(1, 4); i++) begin
                tx_q.push_back(8'($urandom));
                nack_plan[i] = ($urandom_range(0, 2) == 0);
            end
            i2c_xfer(150);
            i2c_check("i2c_rand");
        end
    endtask

    // ---------------- boot vectors ----------------
    typedef struct {
        logic [31:0] entry;
        int          zeros;
        logic [31:0] poll_data;
        logic [31:0] final_data;
        bit          gnt_rand;
        bit          inject;
        logic [31:0] exp_status;
    } boot_vec_t;

    boot_vec_t bv[3];

    task automatic run_boot(input boot_vec_t v);
        int low, n;
        zeros = v.zeros; poll_data = v.poll_data;
        final_data = v.final_data; gnt_rand = v.gnt_rand;
        @(negedge clk);
        entry = v.entry;
        boot_start = 1'b1;
        @(negedge clk);
        boot_start = 1'b0;
        entry = $urandom;
        chk("boot_done_cleared", 32'(boot_done), 32'd0);
        low = 0;
        while (!pms_rst_n && low < 5000) begin
            low++;
            if (v.inject && low == 100) begin
                boot_start = 1'b1;
                entry = 32'hFFFF_FFFF;
            end else begin
                boot_start = 1'b0;
            end
            @(negedge clk);
        end
        boot_start = 1'b0;
        chk("rst_low_cycles", 32'(low), 32'(RST_CYCLES));
        n = 0;
        while (!boot_done && n < 30000) begin @(negedge clk); n++; end
        chk("boot_done", 32'(boot_done), 32'd1);
        chk("wr_count", 32'(wa_q.size()), 32'd3);
        if (wa_q.size() == 3) begin
            chk("wr0_addr", wa_q[0], CSR_BASE);
            chk("wr0_data", wd_q[0], BOOTMODE);
            chk("wr1_addr", wa_q[1], CSR_BASE + 32'h4);
            chk("wr1_data", wd_q[1], v.entry);
            chk("wr2_addr", wa_q[2], CSR_BASE + 32'h8);
            chk("wr2_data", wd_q[2], 32'h1);
        end
        chk("rd_count", 32'(ra_q.size()), 32'(v.zeros + 1));
        for (int i = 0; i < ra_q.size(); i++) begin
            chk("rd_addr", ra_q[i], CSR_BASE + 32'hC);
            if (i > 0)
                chk("rd_gap_ok", 32'(rc_q[i] - rc_q[i-1] >= POLL_CYCLES), 32'd1);
        end
        chk("exit_status", exit_status, v.exp_status);
        chk("pms_rst_released", 32'(pms_rst_n), 32'd1);
    endtask

    initial begin
        int t;
        bv[0] = '{32'h1C00_0880, 2, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h0};
        bv[1] = '{32'h1C00_0000, 0, 32'h0000_0000, 32'h8000_0001, 1'b0, 1'b0, 32'h1};
        bv[2] = '{32'hDEAD_BEE0, 1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h7FFF_FFFF};

        repeat (3) @(negedge clk);
        chk("rst_pms_rst_no", 32'(pms_rst_n), 32'd0);
        chk("rst_reg_req", 32'(reg_req), 32'd0);
        chk("rst_reg_addr", reg_addr, 32'd0);
        chk("rst_reg_wdata", reg_wdata, 32'd0);
        chk("rst_boot_done", 32'(boot_done), 32'd0);
        chk("rst_exit_status", exit_status, 32'd0);
        chk("rst_scl_sda", {30'd0, scl, sda_oe}, 32'd2);
        chk("rst_i2c_flags", {28'd0, i2c_ready, i2c_busy, nack, 1'b0}, 32'd0);
        chk("rst_nack_cnt", 32'(nack_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        tx_q = '{8'hA0, 8'h55, 8'h3C};
        foreach (nack_plan[i]) nack_plan[i] = 1'b0;
        i2c_xfer(0);
        i2c_check("i2c_ack_all");

        nack_plan[1] = 1'b1;
        i2c_xfer(0);
        i2c_check("i2c_nack_b2");

        for (int i = 0; i < 2; i++) run_boot(bv[i]);
        fork
            run_boot(bv[2]);
            i2c_random(5);
        join

        tx_q.delete();
        for (int i = 0; i < 260; i++) begin
            tx_q.push_back(8'($urandom));
            nack_plan[i] = 1'b1;
        end
        i2c_xfer(0);
        i2c_check("i2c_nack_sat");

        // stall in HOLD, then reset in the middle of the next byte
        foreach (nack_plan[i]) nack_plan[i] = 1'b0;
        i2c_data = 8'h5A; i2c_last = 1'b0; i2c_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!i2c_ready && t < 4000);
        i2c_valid = 1'b0;
        repeat (200) @(negedge clk);
        chk("hold_scl_low", {30'd0, scl, i2c_busy}, 32'd1);
        repeat (50) @(negedge clk);
        chk("hold_scl_still_low", 32'(scl), 32'd0);
        chk("hold_rx_count", 32'(rx.size()), 32'd1);
        i2c_data = 8'hC3; i2c_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!i2c_ready && t < 4000);
        i2c_valid = 1'b0;
        t = 0;
        while (!(scl == 1'b0 && sda_oe == 1'b1 && t > 4) && t < 400) begin
            @(negedge clk); t++;
        end
        chk("pre_reset_driving", 32'(sda_oe), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_scl_sda", {30'd0, scl, sda_oe}, 32'd2);
        chk("arst_i2c_flags", {28'd0, i2c_ready, i2c_busy, nack, 1'b0}, 32'd0);
        chk("arst_boot", {30'd0, boot_done, pms_rst_n}, 32'd0);
        chk("arst_exit_status", exit_status, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        tx_q = '{8'h81};
        i2c_xfer(0);
        i2c_check("i2c_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
